// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (IF) and load/store (LS) requesters.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed LS-over-IF priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [3:0]        ls_be_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              memory_done_o
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state, state_nx;
  logic own_ls, sel_ls, any_req, gnt, rv;
  assign any_req = if_req_i | ls_req_i;
`ifdef MEM_ARB_RR_EN
  logic last_ls;
  // on a tie, favour whoever was not selected last
  assign sel_ls = ls_req_i & (~if_req_i | ~last_ls);
  always_ff @(posedge clk)
    if (!rst_n) last_ls <= 1'b0;
    else if (state == IDLE && any_req) last_ls <= sel_ls;
`else
  assign sel_ls = ls_req_i;
`endif
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    gnt = (state == REQ) & mem_gnt_i;
    rv = (state == RESP) & mem_rvalid_i;
    state_nx = (state == IDLE) ? (any_req ? REQ : IDLE) :
               (state == REQ) ? (mem_gnt_i ? RESP : REQ) :
               (mem_rvalid_i ? IDLE : RESP);
    if_gnt_o = gnt & ~own_ls;
    ls_gnt_o = gnt & own_ls;
    if_rvalid_o = rv & ~own_ls;
    ls_rvalid_o = rv & own_ls;
    if_rdata_o = if_rvalid_o ? mem_rdata_i : '0;
    ls_rdata_o = ls_rvalid_o ? mem_rdata_i : '0;
  end
  // the request is committed here; the bus only ever sees these registers
  always_ff @(posedge clk)
    if (!rst_n) begin
      own_ls <= 1'b0;
      mem_req_o <= 1'b0;
      mem_we_o <= 1'b0;
      mem_be_o <= '0;
      mem_addr_o <= '0;
      mem_wdata_o <= '0;
      memory_done_o <= 1'b1;
    end else begin
      if (state == IDLE && any_req) begin
        own_ls <= sel_ls;
        mem_req_o <= 1'b1;
        mem_we_o <= sel_ls & ls_we_i;
        mem_be_o <= sel_ls ? ls_be_i : 4'hF;
        mem_addr_o <= sel_ls ? ls_addr_i : if_addr_i;
        mem_wdata_o <= sel_ls ? ls_wdata_i : '0;
        memory_done_o <= ~sel_ls;
      end
      if (gnt) mem_req_o <= 1'b0;
      if (rv) memory_done_o <= 1'b1;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed bench against a transaction-level arbiter model.
// Build with MEM_ARB_RR_EN defined to check the round-robin variant.
module tb_mem_port_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic if_req_i = 0, ls_req_i = 0, ls_we_i = 0, mem_gnt_i = 0, mem_rvalid_i = 0;
  logic [31:0] if_addr_i = 0, ls_addr_i = 0, ls_wdata_i = 0, mem_rdata_i = 0;
  logic [3:0] ls_be_i = 0;
  logic if_gnt_o, if_rvalid_o, ls_gnt_o, ls_rvalid_o, mem_req_o, mem_we_o, memory_done_o;
  logic [31:0] if_rdata_o, ls_rdata_o, mem_addr_o, mem_wdata_o;
  logic [3:0] mem_be_o;
  int vectors = 0, miscompares = 0;
  bit pend_if, pend_ls, m_ls_we;
  logic [31:0] m_if_addr, m_ls_addr, m_ls_wdata;
  logic [3:0] m_ls_be;
`ifdef MEM_ARB_RR_EN
  bit last_ls;
`endif

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .memory_done_o(memory_done_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    if_req_i = pend_if;
    if_addr_i = m_if_addr;
    ls_req_i = pend_ls;
    ls_we_i = m_ls_we;
    ls_be_i = m_ls_be;
    ls_addr_i = m_ls_addr;
    ls_wdata_i = m_ls_wdata;
  endtask

  task automatic new_if(input logic [31:0] a);
    pend_if = 1;
    m_if_addr = a;
  endtask

  task automatic new_ls(input bit we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
    pend_ls = 1;
    m_ls_we = we;
    m_ls_be = be;
    m_ls_addr = a;
    m_ls_wdata = d;
  endtask

  task automatic model_reset();
    pend_if = 0;
    pend_ls = 0;
`ifdef MEM_ARB_RR_EN
    last_ls = 0;
`endif
  endtask

  // One full transaction from the IDLE cycle; the model picks the owner from pending requests.
  task automatic run_txn(input int gdly, input int rdly, input logic [31:0] rdata, input bit drop);
    bit own_ls;
    logic [69:0] exp_bus, act_bus;
    logic [65:0] exp_rsp;
    logic [1:0] exp_gnt;
    drive_reqs();
    mem_gnt_i = 0;
    mem_rvalid_i = 0;
    #1;
    vectors++;
    if ({mem_req_o, if_gnt_o, ls_gnt_o, if_rvalid_o, ls_rvalid_o, memory_done_o} !== 6'b000001) begin
      miscompares++;
      $display("FAIL idle_state: got %b want 000001",
               {mem_req_o, if_gnt_o, ls_gnt_o, if_rvalid_o, ls_rvalid_o, memory_done_o});
    end
`ifdef MEM_ARB_RR_EN
    own_ls = pend_ls && (!pend_if || !last_ls);
    last_ls = own_ls;
`else
    own_ls = pend_ls;
`endif
    exp_bus = own_ls ? {1'b1, m_ls_we, m_ls_be, m_ls_addr, m_ls_wdata} : {1'b1, 1'b0, 4'hF, m_if_addr, 32'h0};
    tick();
    if (drop) begin
      if (own_ls) begin ls_req_i = 0; ls_addr_i = $urandom; ls_wdata_i = $urandom; ls_be_i = 4'($urandom); end
      else begin if_req_i = 0; if_addr_i = $urandom; end
    end
    for (int i = 0; i <= gdly; i++) begin
      mem_gnt_i = (i == gdly);
      #1;
      act_bus = {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, own_ls ? mem_wdata_o : 32'h0};
      exp_gnt = (i == gdly) ? (own_ls ? 2'b01 : 2'b10) : 2'b00;
      vectors++;
      if (act_bus !== exp_bus) begin
        miscompares++;
        $display("FAIL req_bus: got %h want %h", act_bus, exp_bus);
      end
      vectors++;
      if ({if_gnt_o, ls_gnt_o} !== exp_gnt || memory_done_o !== !own_ls) begin
        miscompares++;
        $display("FAIL req_gnt: got gnt=%b done=%b want gnt=%b done=%b",
                 {if_gnt_o, ls_gnt_o}, memory_done_o, exp_gnt, !own_ls);
      end
      tick();
    end
    mem_gnt_i = 0;
    if (own_ls) pend_ls = 0; else pend_if = 0;
    drive_reqs();
    for (int i = 0; i <= rdly; i++) begin
      mem_rvalid_i = (i == rdly);
      mem_rdata_i = (i == rdly) ? rdata : $urandom;
      #1;
      exp_rsp = (i != rdly) ? 66'h0 : own_ls ? {1'b0, 32'h0, 1'b1, rdata} : {1'b1, rdata, 1'b0, 32'h0};
      vectors++;
      if ({if_rvalid_o, if_rdata_o, ls_rvalid_o, ls_rdata_o} !== exp_rsp) begin
        miscompares++;
        $display("FAIL resp: got %h want %h", {if_rvalid_o, if_rdata_o, ls_rvalid_o, ls_rdata_o}, exp_rsp);
      end
      vectors++;
      if ({mem_req_o, if_gnt_o, ls_gnt_o, memory_done_o} !== {3'b000, !own_ls}) begin
        miscompares++;
        $display("FAIL resp_ctrl: got %b want %b", {mem_req_o, if_gnt_o, ls_gnt_o, memory_done_o}, {3'b000, !own_ls});
      end
      tick();
    end
    mem_rvalid_i = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    drive_reqs();
    tick();
    tick();
    rst_n = 1;
    #1;
    vectors++;
    if ({if_gnt_o, if_rvalid_o, if_rdata_o, ls_gnt_o, ls_rvalid_o, ls_rdata_o, mem_req_o, mem_we_o,
         mem_be_o, mem_addr_o, mem_wdata_o, memory_done_o} !== {138'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_outputs: req=%b addr=%h done=%b want all 0 and done=1", mem_req_o, mem_addr_o, memory_done_o);
    end
    tick();
  endtask

  task automatic test_contention();
    new_if($urandom);
    new_ls(1'($urandom), 4'($urandom), $urandom, $urandom);
    for (int n = 0; n < 8 && (pend_if || pend_ls); n++) begin
      run_txn($urandom_range(0, 2), $urandom_range(0, 2), $urandom, 0);
      if (n < 2 && !pend_ls) new_ls(1'($urandom), 4'($urandom), $urandom, $urandom);
      if (n < 2 && !pend_if) new_if($urandom);
    end
  endtask

  task automatic test_lone_fetch();
    new_if(32'h100);
    run_txn(1, 1, 32'h00000013, 0);
  endtask

  task automatic test_store();
    new_ls(1, 4'b0011, 32'h2000, 32'hDEADBEEF);
    run_txn(0, 0, $urandom, 0);
  endtask

  task automatic test_gnt_stall();
    new_ls(0, 4'hF, $urandom, $urandom);
    run_txn(5, 2, $urandom, 0);
    new_if($urandom);
    run_txn(5, 0, $urandom, 1);
  endtask

  task automatic test_spurious_rvalid();
    drive_reqs();
    for (int i = 0; i < 2; i++) begin
      mem_rvalid_i = 1;
      mem_rdata_i = $urandom;
      #1;
      vectors++;
      if ({mem_req_o, if_rvalid_o, if_rdata_o, ls_rvalid_o, ls_rdata_o, memory_done_o} !== {67'h0, 1'b1}) begin
        miscompares++;
        $display("FAIL spurious_rvalid: got req=%b ifv=%b lsv=%b done=%b want 0 0 0 1",
                 mem_req_o, if_rvalid_o, ls_rvalid_o, memory_done_o);
      end
      tick();
    end
    mem_rvalid_i = 0;
  endtask

  task automatic test_reset_in_resp();
    new_ls(1, 4'hC, $urandom, $urandom);
    drive_reqs();
    tick();
    mem_gnt_i = 1;
    tick();
    mem_gnt_i = 0;
    pend_ls = 0;
    drive_reqs();
    #1;
    vectors++;
    if (memory_done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL resp_done_low: got %b want 0", memory_done_o);
    end
    rst_n = 0;
    model_reset();
    tick();
    rst_n = 1;
    mem_rvalid_i = 1;
    mem_rdata_i = $urandom;
    #1;
    vectors++;
    if ({if_gnt_o, if_rvalid_o, if_rdata_o, ls_gnt_o, ls_rvalid_o, ls_rdata_o, mem_req_o, mem_we_o,
         mem_be_o, mem_addr_o, mem_wdata_o, memory_done_o} !== {138'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_in_resp: req=%b we=%b be=%h addr=%h lsv=%b done=%b want all 0 and done=1",
               mem_req_o, mem_we_o, mem_be_o, mem_addr_o, ls_rvalid_o, memory_done_o);
    end
    tick();
    mem_rvalid_i = 0;
    test_lone_fetch();
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      if (!pend_if && $urandom_range(0, 1)) new_if($urandom);
      if (!pend_ls && $urandom_range(0, 1)) new_ls(1'($urandom), 4'($urandom), $urandom, $urandom);
      if (pend_if || pend_ls)
        run_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'($urandom));
      else
        test_spurious_rvalid();
    end
    while (pend_if || pend_ls) run_txn(0, 0, $urandom, 0);
  endtask

  initial begin
    test_reset();
    test_contention();
    test_lone_fetch();
    test_store();
    test_gnt_stall();
    test_spurious_rvalid();
    test_reset_in_resp();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between the instruction-fetch requester (IF) and the load/store requester (LS).
- Sequences one transaction at a time: arbitrate, issue with a req/gnt handshake, then wait for rvalid and route the response to its owner.
- Generates memory_done_o, which the core's control block uses to derive its fetch stall.
- Sits between the datapath's fetch/LSU ports and the memory bus.

Parameters:
- ADDR_W, 32, address width (matches addr_t).
- DATA_W, 32, data width (matches data_t).

Ports:
- clk  input  1  core clock
- rst_n  input  1  synchronous active-low reset
- if_req_i  input  1  fetch request; held until if_gnt_o
- if_addr_i  input  ADDR_W  fetch address
- if_gnt_o  output  1  fetch request accepted (1-cycle pulse)
- if_rvalid_o  output  1  fetch data valid (1-cycle pulse)
- if_rdata_o  output  DATA_W  fetch data
- ls_req_i  input  1  load/store request; held until ls_gnt_o
- ls_we_i  input  1  1=store, 0=load
- ls_be_i  input  4  byte enables
- ls_addr_i  input  ADDR_W  load/store address
- ls_wdata_i  input  DATA_W  store data
- ls_gnt_o  output  1  LS request accepted (1-cycle pulse)
- ls_rvalid_o  output  1  load data / store ack valid (1-cycle pulse)
- ls_rdata_o  output  DATA_W  load data
- mem_req_o  output  1  bus request
- mem_we_o  output  1  bus write enable
- mem_be_o  output  4  bus byte enables
- mem_addr_o  output  ADDR_W  bus address
- mem_wdata_o  output  DATA_W  bus write data
- mem_gnt_i  input  1  bus accepted request
- mem_rvalid_i  input  1  bus response valid
- mem_rdata_i  input  DATA_W  bus read data
- memory_done_o  output  1  no LS transaction pending

Behaviour:
- Reset:
  - rst_n=0 at a clk edge forces state IDLE and owner=IF (RR pointer to IF).
  - All mem_* outputs, gnt/rvalid outputs and rdata outputs reset to 0.
  - memory_done_o resets to 1.
- States: IDLE, REQ, RESP.
- IDLE:
  - If any request is present, select an owner.
  - Latch the owner's addr/we/be/wdata into registers. IF transactions force we=0 and be=4'hF.
  - Go to REQ. No requests: stay in IDLE.
  - Fixed priority: LS wins when both requesters assert.
- REQ:
  - mem_req_o=1 and mem_* are driven from the registers. Bus outputs are registered, so nothing on the bus changes combinationally with requester inputs.
  - On mem_gnt_i=1, pulse the owner's *_gnt_o in that same cycle and go to RESP.
  - mem_req_o falls on the following cycle.
- RESP:
  - mem_req_o=0.
  - On mem_rvalid_i=1, drive the owner's *_rvalid_o=1 and *_rdata_o=mem_rdata_i in the same cycle (combinational pass-through), then go to IDLE.
  - The non-owner's rvalid_o stays 0. rdata_o is 0 whenever its rvalid_o is 0.
- Bus assumption: mem_rvalid_i never asserts in REQ, or in the same cycle as mem_gnt_i. An unexpected mem_rvalid_i in IDLE or REQ is ignored.
- Throughput:
  - Minimum 3 cycles per transaction: IDLE → REQ (gnt) → RESP (rvalid).
  - Back-to-back requests always incur the IDLE arbitration cycle.
- memory_done_o = 0 from the cycle LS is selected in IDLE (registered: low from the next cycle) through the cycle ls_rvalid_o is pulsed; 1 otherwise.
- A requester that drops its req before gnt after being latched is still serviced: the request is committed once latched.
- Reset mid-operation: the transaction is abandoned with no rvalid. The bus must be reset in the same cycle.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. On a tie in IDLE, grant the requester not served last. The last-served bit updates on each selection and resets to IF, so LS wins the first tie. A single requester is always granted.
- Undefined: fixed priority, LS over IF; no last-served register.

Test Plan:
- Lone fetch: if_req_i=1, if_addr_i=0x100, mem_gnt_i the cycle after mem_req_o rises, mem_rvalid_i=1 with rdata 0x00000013 two cycles later → mem_addr_o=0x100, mem_we_o=0, mem_be_o=4'hF; if_gnt_o one pulse; if_rvalid_o one pulse with if_rdata_o=0x00000013; memory_done_o stays 1.
- Store: ls_req_i=1, we=1, be=4'b0011, addr 0x2000, wdata 0xDEADBEEF → bus carries exactly those values; ls_rvalid_o pulses on ack; memory_done_o low from the cycle after LS selection through the ack cycle.
- Contention: if_req_i and ls_req_i both held → fixed mode serves LS then IF. With MEM_ARB_RR_EN, sustained contention alternates LS, IF, LS.
- Gnt stall: mem_gnt_i held 0 for 5 cycles in REQ → mem_req_o and mem_addr_o stay stable; no *_gnt_o until mem_gnt_i=1.
- Spurious rvalid: mem_rvalid_i=1 in IDLE → no *_rvalid_o; state unchanged.
- Reset in RESP: rst_n=0 for 1 cycle → the next cycle shows all outputs 0, memory_done_o=1, state IDLE; a subsequent fetch completes normally.
